// File: rtl/int_request_ctrl_pkg.sv
// Shared types and constants for the interrupt request controller:
// FSM state encoding, vector widths and the edge-type mask helper.
package int_request_ctrl_pkg;

   localparam int HW_IRQ_W  = 6;
   localparam int INT_W     = 8;
   localparam int TIMER_BIT = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      ACKED   = 2'd2
   } irq_state_t;

   // Bits that behave as sticky edge requests: edge-mode hardware lines plus the timer.
   function automatic logic [INT_W-1:0] edge_type_mask(input logic [HW_IRQ_W-1:0] edge_mode);
      logic [INT_W-1:0] mask;
      mask = '0;
      mask[HW_IRQ_W-1:0] = edge_mode;
      mask[TIMER_BIT] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/int_request_ctrl_if.sv
// CP0 handshake and software control bus of the interrupt request controller.
interface int_request_ctrl_if;
   import int_request_ctrl_pkg::*;

   logic [INT_W-1:0] int_o;
   logic [INT_W-1:0] pending_o;
   logic             entr_ack;
   logic             sr_exl;
   logic             clr_valid;
   logic [INT_W-1:0] clr_mask;
   logic             timer_load;
   logic [31:0]      timer_period;

   modport master (
      output int_o, pending_o,
      input  entr_ack, sr_exl, clr_valid, clr_mask, timer_load, timer_period
   );

   modport slave (
      input  int_o, pending_o,
      output entr_ack, sr_exl, clr_valid, clr_mask, timer_load, timer_period
   );

endinterface

// File: rtl/int_request_ctrl_irq_sync.sv
// Two-flop synchronizer for one raw interrupt line plus a delay flop for
// rising-edge detection on the synchronized value.
module irq_sync (
   input  logic clk,
   input  logic resetn,
   input  logic irq,
   output logic level,
   output logic rise
);

   logic s1, s2, s3;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= irq;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level = s2;
   assign rise  = s2 & ~s3;

endmodule

// File: rtl/int_request_ctrl.sv
// Interrupt request controller: collects synchronized hardware lines and a
// periodic timer into a pending register and presents snapshots to CP0.
module int_request_ctrl
   import int_request_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic [HW_IRQ_W-1:0] irq_in,
   input  logic [HW_IRQ_W-1:0] edge_mode,
   int_request_ctrl_if.master  bus
);

   logic [HW_IRQ_W-1:0] sync_level;
   logic [HW_IRQ_W-1:0] sync_rise;

   for (genvar g = 0; g < HW_IRQ_W; g++) begin : g_sync
      irq_sync u_sync (
         .clk    (clk),
         .resetn (resetn),
         .irq    (irq_in[g]),
         .level  (sync_level[g]),
         .rise   (sync_rise[g])
      );
   end

   logic [31:0] period;
   logic [31:0] count;
   logic        timer_fire;

   // A load takes priority over a terminal count on the same edge.
   assign timer_fire = !bus.timer_load && (period != 32'd0) && (count == 32'd1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         period <= '0;
         count  <= '0;
      end else if (bus.timer_load) begin
         period <= bus.timer_period;
         count  <= bus.timer_period;
      end else if (period != 32'd0) begin
         if (count == 32'd1) begin
            count <= period;
         end else begin
            count <= count - 32'd1;
         end
      end
   end

   irq_state_t       state, next_state;
   logic [INT_W-1:0] int_q, int_next;
   logic [INT_W-1:0] pending, pending_next;
   logic [INT_W-1:0] edge_type, sw_clr, ack_clr, set_vec, level_vec;

   assign edge_type = edge_type_mask(edge_mode);
   assign sw_clr    = bus.clr_valid ? (bus.clr_mask & edge_type) : '0;
   assign ack_clr   = (state == PRESENT && bus.entr_ack) ? (int_q & edge_type) : '0;

   // Level lines follow the synchronizer; edge bits are sticky and a set beats any clear.
   always_comb begin
      set_vec   = '0;
      level_vec = '0;
      set_vec[HW_IRQ_W-1:0]   = sync_rise & edge_mode;
      set_vec[TIMER_BIT]      = timer_fire;
      level_vec[HW_IRQ_W-1:0] = sync_level & ~edge_mode;
      pending_next = (((pending & ~(sw_clr | ack_clr)) | set_vec) & edge_type) | level_vec;
   end

   always_comb begin
      next_state = state;
      int_next   = int_q;
      case (state)
         IDLE: begin
            int_next = '0;
            if (pending != '0 && !bus.sr_exl) begin
               int_next   = pending;
               next_state = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.entr_ack) begin
               int_next   = '0;
               next_state = ACKED;
            end else if ((sw_clr & int_q) != '0) begin
               int_next   = '0;
               next_state = IDLE;
            end
         end
         ACKED: begin
            int_next = '0;
            if (!bus.sr_exl) begin
               next_state = IDLE;
            end
         end
         default: begin
            int_next   = '0;
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         int_q   <= '0;
         pending <= '0;
      end else begin
         state   <= next_state;
         int_q   <= int_next;
         pending <= pending_next;
      end
   end

   assign bus.int_o     = int_q;
   assign bus.pending_o = pending;

endmodule

// File: tb/tb_int_request_ctrl.sv
// Self-checking bench for int_request_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_int_request_ctrl;
   import int_request_ctrl_pkg::*;

   localparam int HIST = 1024;
   localparam logic [1:0] PH_IDLE = 2'd0;
   localparam logic [1:0] PH_PRES = 2'd1;
   localparam logic [1:0] PH_ACK  = 2'd2;

   typedef struct packed {
      logic [7:0] pend;
      logic [7:0] pres;
      logic [1:0] phase;
   } model_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [5:0] irq_in = '0;
   logic [5:0] edge_mode = '0;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   int_request_ctrl_if bus();

   int_request_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .irq_in    (irq_in),
      .edge_mode (edge_mode),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   model_t      m;
   logic [31:0] period_m;
   int          load_edge = 0;
   int          rst_edge = 0;
   int          cyc = 0;
   logic [5:0]  samp [0:HIST-1];

   // Raw irq_in as sampled k edges before the current one; nothing before reset counts.
   function automatic logic [5:0] ago(input int k);
      int idx;
      idx = cyc - k;
      if (idx < rst_edge || idx < 0) return 6'h00;
      return samp[idx % HIST];
   endfunction

   function automatic logic timer_due();
      if (bus.timer_load || period_m == 32'd0) return 1'b0;
      return ((cyc - load_edge) % int'(period_m)) == 0;
   endfunction

   function automatic model_t model_step(input model_t cur, input logic [5:0] lvl,
                                         input logic [5:0] rise, input logic tset,
                                         input logic [5:0] em, input logic ack,
                                         input logic exl, input logic cv,
                                         input logic [7:0] cm);
      logic [7:0] et, sw, ak, sets;
      model_t n;
      et   = {1'b1, 1'b0, em};
      sw   = cv ? (cm & et) : 8'h00;
      ak   = (cur.phase == PH_PRES && ack) ? (cur.pres & et) : 8'h00;
      sets = {tset, 1'b0, rise & em};
      n = cur;
      n.pend = (((cur.pend & ~sw & ~ak) | sets) & et) | ({2'b00, lvl} & ~et);
      case (cur.phase)
         PH_IDLE: if (cur.pend != 8'h00 && !exl) begin
            n.pres  = cur.pend;
            n.phase = PH_PRES;
         end
         PH_PRES: if (ack) begin
            n.pres  = 8'h00;
            n.phase = PH_ACK;
         end else if ((sw & cur.pres) != 8'h00) begin
            n.pres  = 8'h00;
            n.phase = PH_IDLE;
         end
         default: if (!exl) n.phase = PH_IDLE;
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m         <= '0;
         period_m  <= '0;
         load_edge <= 0;
         rst_edge  <= cyc;
      end else begin
         samp[cyc % HIST] <= irq_in;
         cyc <= cyc + 1;
         if (bus.timer_load) begin
            period_m  <= bus.timer_period;
            load_edge <= cyc;
         end
         m <= model_step(m, ago(2), ago(2) & ~ago(3), timer_due(), edge_mode,
                         bus.entr_ack, bus.sr_exl, bus.clr_valid, bus.clr_mask);
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en && resetn) begin
         checkOutput("model_int_o", bus.int_o, m.pres);
         checkOutput("model_pending_o", bus.pending_o, m.pend);
      end
   end

   task automatic applyStimulus(input logic [5:0] irq, input logic ack, input logic exl,
                                input logic cv, input logic [7:0] cm,
                                input logic tl, input logic [31:0] tp);
      irq_in           = irq;
      bus.entr_ack     = ack;
      bus.sr_exl       = exl;
      bus.clr_valid    = cv;
      bus.clr_mask     = cm;
      bus.timer_load   = tl;
      bus.timer_period = tp;
      @(negedge clk);
   endtask

   task automatic idle(input logic [5:0] irq, input logic exl);
      applyStimulus(irq, 1'b0, exl, 1'b0, 8'h00, 1'b0, 32'd0);
   endtask

   task automatic doReset(input string tag);
      #2 resetn = 1'b0;
      #1;
      checkOutput({tag, "_rst_int_o"}, bus.int_o, 8'h00);
      checkOutput({tag, "_rst_pending_o"}, bus.pending_o, 8'h00);
      checkOutput({tag, "_rst_state"}, 8'(dut.state), 8'(IDLE));
      irq_in           = '0;
      bus.entr_ack     = 1'b0;
      bus.sr_exl       = 1'b0;
      bus.clr_valid    = 1'b0;
      bus.clr_mask     = '0;
      bus.timer_load   = 1'b0;
      bus.timer_period = '0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   logic [31:0] r, r2;
   logic        exl_r;

   initial begin
      bus.entr_ack     = 1'b0;
      bus.sr_exl       = 1'b0;
      bus.clr_valid    = 1'b0;
      bus.clr_mask     = '0;
      bus.timer_load   = 1'b0;
      bus.timer_period = '0;
      repeat (2) @(negedge clk);
      resetn   = 1'b1;
      check_en = 1'b1;
      checkOutput("init_int_o", bus.int_o, 8'h00);
      checkOutput("init_pending_o", bus.pending_o, 8'h00);
      edge_mode = 6'b111110;

      // Single-cycle pulse on edge line 2, then acknowledge.
      applyStimulus(6'h04, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0);
      idle(6'h00, 1'b0);
      checkOutput("edge2_not_yet", bus.pending_o, 8'h00);
      idle(6'h00, 1'b0);
      checkOutput("edge2_pending", bus.pending_o, 8'h04);
      checkOutput("edge2_int_early", bus.int_o, 8'h00);
      idle(6'h00, 1'b0);
      checkOutput("edge2_int_o", bus.int_o, 8'h04);
      checkOutput("edge2_state", 8'(dut.state), 8'(PRESENT));
      applyStimulus(6'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0);
      checkOutput("edge2_ack_pending", bus.pending_o, 8'h00);
      checkOutput("edge2_ack_int", bus.int_o, 8'h00);
      checkOutput("edge2_ack_state", 8'(dut.state), 8'(ACKED));
      doReset("t1");

      // Level line 0 held through the acknowledge is re-presented.
      repeat (3) idle(6'h01, 1'b0);
      checkOutput("lvl0_pending", bus.pending_o, 8'h01);
      idle(6'h01, 1'b0);
      checkOutput("lvl0_int", bus.int_o, 8'h01);
      applyStimulus(6'h01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'd0);
      checkOutput("lvl0_ack_pending", bus.pending_o, 8'h01);
      checkOutput("lvl0_ack_int", bus.int_o, 8'h00);
      idle(6'h01, 1'b1);
      checkOutput("lvl0_exl_int", bus.int_o, 8'h00);
      idle(6'h01, 1'b0);
      idle(6'h01, 1'b0);
      checkOutput("lvl0_represent", bus.int_o, 8'h01);
      doReset("t2");

      // Timer with period 5, software clear while presented, then disable.
      applyStimulus(6'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'd5);
      for (int k = 1; k <= 5; k++) begin
         idle(6'h00, 1'b0);
         checkOutput("tmr_first", bus.pending_o, (k == 5) ? 8'h80 : 8'h00);
      end
      applyStimulus(6'h00, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 32'd0);
      checkOutput("tmr_snap_int", bus.int_o, 8'h80);
      checkOutput("tmr_cleared", bus.pending_o, 8'h00);
      for (int k = 7; k <= 10; k++) begin
         idle(6'h00, 1'b0);
         checkOutput("tmr_second", bus.pending_o, (k == 10) ? 8'h80 : 8'h00);
      end
      applyStimulus(6'h00, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 32'd0);
      checkOutput("swclr_drop_int", bus.int_o, 8'h00);
      checkOutput("swclr_state", 8'(dut.state), 8'(IDLE));
      applyStimulus(6'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 32'd0);
      for (int k = 0; k < 20; k++) begin
         idle(6'h00, 1'b0);
         checkOutput("tmr_off", bus.pending_o, 8'h00);
      end
      doReset("t3");

      // Clear and set of bit 3 on the same edge: the set wins.
      applyStimulus(6'h08, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0);
      idle(6'h00, 1'b0);
      applyStimulus(6'h00, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 32'd0);
      checkOutput("setwins_pending", bus.pending_o, 8'h08);
      idle(6'h00, 1'b0);
      checkOutput("setwins_int", bus.int_o, 8'h08);
      doReset("t4");

      // Present 8'h81, then reset in the middle of the handshake.
      applyStimulus(6'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 32'd3);
      idle(6'h01, 1'b1);
      idle(6'h01, 1'b1);
      idle(6'h01, 1'b1);
      checkOutput("t5_pending", bus.pending_o, 8'h81);
      checkOutput("t5_held", bus.int_o, 8'h00);
      idle(6'h01, 1'b0);
      checkOutput("t5_int", bus.int_o, 8'h81);
      doReset("t5");

      // Arrival on bit 4 while ACKED with EXL high.
      applyStimulus(6'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0);
      idle(6'h00, 1'b0);
      idle(6'h00, 1'b0);
      idle(6'h00, 1'b0);
      checkOutput("t6_int1", bus.int_o, 8'h02);
      applyStimulus(6'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 32'd0);
      applyStimulus(6'h10, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'd0);
      idle(6'h00, 1'b1);
      idle(6'h00, 1'b1);
      checkOutput("t6_pending", bus.pending_o, 8'h10);
      checkOutput("t6_int_held", bus.int_o, 8'h00);
      idle(6'h00, 1'b1);
      checkOutput("t6_state", 8'(dut.state), 8'(ACKED));
      idle(6'h00, 1'b0);
      checkOutput("t6_idle_int", bus.int_o, 8'h00);
      idle(6'h00, 1'b0);
      checkOutput("t6_int2", bus.int_o, 8'h10);
      doReset("t6");

      // Randomized traffic, including stray acks, clears and timer reloads.
      exl_r = 1'b0;
      for (int seg = 0; seg < 12; seg++) begin
         r = $urandom;
         edge_mode = r[5:0];
         for (int c = 0; c < 250; c++) begin
            r  = $urandom;
            r2 = $urandom;
            if (r2[2:0] == 3'd0) exl_r = ~exl_r;
            applyStimulus(r[5:0] & r[13:8], r[17:16] == 2'd0, exl_r, r[20:18] == 3'd0,
                          r2[15:8], r2[23:18] == 6'd0, 32'($urandom_range(0, 12)));
         end
         if (seg % 4 == 3) doReset("rnd");
      end

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/int_request_ctrl.md
INT_REQUEST_CTRL -- requirements
Module: int_request_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and resetn.
REQ-002 Port clk: input, 1 bit, rising-edge clock.
REQ-003 Port resetn: input, 1 bit, asynchronous active-low reset.
REQ-004 Port irq_in: input, 6 bits, raw asynchronous hardware interrupt lines, active-high.
REQ-005 Port edge_mode: input, 6 bits, quasi-static; 1 = edge-triggered line, 0 = level-triggered line.
REQ-006 Port entr_ack: input, 1 bit, one-cycle pulse from CP0 meaning the interrupt was taken.
REQ-007 Port sr_exl: input, 1 bit, CP0 Status.EXL; high while the handler runs.
REQ-008 Port clr_valid: input, 1 bit, software clear strobe.
REQ-009 Port clr_mask: input, 8 bits, pending bits to clear when clr_valid=1.
REQ-010 Port timer_load: input, 1 bit, loads the timer period.
REQ-011 Port timer_period: input, 32 bits, timer period; 0 disables the timer.
REQ-012 Port int_o: output, 8 bits, presented request vector to CP0 int[7:0].
REQ-013 Port pending_o: output, 8 bits, live pending register.

Function
REQ-014 Each irq_in bit SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop (s3).
REQ-015 Edge lines SHALL set pending[i] when s2 & ~s3; a rising irq_in sampled at edge k sets pending at edge k+2.
REQ-016 Level lines SHALL make pending[i] equal s2 every cycle and ignore clears and acks.
REQ-017 pending[6] SHALL be constant 0.
REQ-018 The timer SHALL be a 32-bit down-counter; timer_load writes both the period and the counter.
REQ-019 When the counter is 1 and the period is nonzero, the timer SHALL set pending[7] and reload the period on the same edge.
REQ-020 While the period is 0, the counter SHALL hold and pending[7] SHALL never be set.
REQ-021 A clr_valid strobe SHALL clear the edge-type pending bits (bits 0-5 with edge_mode=1, and bit 7) selected by clr_mask.
REQ-022 If a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-023 The FSM SHALL have three states: IDLE, PRESENT and ACKED.
REQ-024 IDLE: int_o = 0; when pending != 0 and sr_exl = 0, the FSM SHALL snapshot pending into int_o and move to PRESENT on the next edge.
REQ-025 PRESENT: int_o SHALL hold stable; level bits SHALL update from the live s2 value.
REQ-026 PRESENT: on entr_ack, the block SHALL clear the snapshot's edge-type bits in pending, clear int_o and move to ACKED.
REQ-027 ACKED: the FSM SHALL return to IDLE on the first cycle sr_exl = 0.
REQ-028 Requests arriving during PRESENT or ACKED SHALL remain pending and be presented in the next IDLE pass.
REQ-029 Presented edge bits cleared by software while in PRESENT SHALL make the FSM drop int_o and return to IDLE; the bits are not re-presented unless they are set again.
REQ-030 entr_ack outside PRESENT SHALL be ignored.

Reset
REQ-031 Asserting resetn low SHALL asynchronously clear s1/s2/s3, pending, int_o, pending_o, the counter and the period, and force IDLE, including mid-handshake.
REQ-032 After deassertion, no request SHALL be presented earlier than 3 edges after irq_in is high.

Structure
REQ-033 A shared package SHALL hold the FSM state enum {IDLE, PRESENT, ACKED}, HW_IRQ_W = 6, INT_W = 8 and TIMER_BIT = 7.
REQ-034 The synchronizer and edge detector SHALL be one sub-module, irq_sync, instantiated once per line.

Verification
REQ-035 Edge line 2: pulse irq_in[2] for 1 cycle with sr_exl = 0 -> pending_o = 8'h04 after 2 edges and int_o = 8'h04 one edge later; entr_ack -> pending_o = 0, FSM = ACKED.
REQ-036 Level line 0: hold irq_in[0] = 1 through entr_ack -> pending_o[0] stays 1; drop sr_exl -> int_o = 8'h01 re-presented.
REQ-037 Timer: load timer_period = 5 -> pending_o[7] sets every 5 cycles; load 0 -> pending_o[7] never sets again.
REQ-038 Same-cycle clear and set: clr_valid with clr_mask = 8'h08 on the edge where bit 3 sets -> pending_o[3] = 1.
REQ-039 Reset in PRESENT with int_o = 8'h81: assert resetn = 0 -> int_o = 0 and pending_o = 0 immediately, FSM = IDLE.
REQ-040 Arrival during ACKED with sr_exl = 1: an edge on bit 4 -> int_o stays 0 until sr_exl = 0, then int_o = 8'h10.
